// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin / fixed-select stream multiplexer.
// Holds the mode encodings and the select-width helper.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Bits needed to index n channels, never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority selector: grants the first requester at or above ptr,
// wrapping modulo N_CH. Purely combinational.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned SW   = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [N_CH-1:0] grant_c,
    output logic [SW-1:0]   grant_idx_c,
    output logic            grant_any_c
);

    always_comb begin
        int unsigned idx;
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = (32'(ptr) + k) % N_CH;
            if (!grant_any_c && req[SW'(idx)]) begin
                grant_c[SW'(idx)] = 1'b1;
                grant_idx_c       = SW'(idx);
                grant_any_c       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output stage with valid/ready handshake.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SW    = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SW-1:0]         sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SW-1:0]         out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Valid vector padded to the full select range so out-of-range sel grants nothing.
    localparam int unsigned NPAD = 1 << SW;

    logic [SW-1:0]   ptr;
    logic            load_c;
    logic [N_CH-1:0] rr_grant_c;
    logic [SW-1:0]   rr_idx_c;
    logic            rr_any_c;
    logic [NPAD-1:0] valid_pad_c;
    logic [NPAD-1:0] sel_onehot_c;
    logic [N_CH-1:0] grant_c;
    logic [SW-1:0]   grant_idx_c;
    logic            xfer_c;

    assign load_c = !out_valid || out_ready;

    rr_arbiter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant_c     (rr_grant_c),
        .grant_idx_c (rr_idx_c),
        .grant_any_c (rr_any_c)
    );

    // Grant multiplexing between fixed select and round-robin; nothing during reset.
    always_comb begin
        valid_pad_c       = NPAD'(in_valid);
        sel_onehot_c      = '0;
        sel_onehot_c[sel] = valid_pad_c[sel];
        grant_c           = '0;
        grant_idx_c       = '0;
        xfer_c            = 1'b0;
        if (!rst && load_c) begin
            if (mode == MODE_RR) begin
                grant_c     = rr_grant_c;
                grant_idx_c = rr_idx_c;
                xfer_c      = rr_any_c;
            end else begin
                grant_c     = N_CH'(sel_onehot_c);
                grant_idx_c = sel;
                xfer_c      = valid_pad_c[sel];
            end
        end
    end

    assign in_ready = grant_c;

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_c) begin
            out_valid <= xfer_c;
            if (xfer_c) begin
                out_data <= in_data[32'(grant_idx_c)*WIDTH +: WIDTH];
                out_ch   <= grant_idx_c;
                if (mode == MODE_RR) begin
                    ptr <= (grant_idx_c == SW'(N_CH - 1)) ? '0 : grant_idx_c + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios with literal expectations, then
// randomized traffic against a behavioural model checked every cycle.
module tb_stream_mux_rr;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int SW    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SW-1:0]         sel;
    logic [WIDTH-1:0]      out_data;
    logic [SW-1:0]         out_ch;
    logic                  out_valid;
    logic                  out_ready;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: contents of the output stage and rotation pointer.
    logic            m_valid = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    int              m_ch    = 0;
    int              m_ptr   = 0;
    int              q_ch[$];
    logic [WIDTH-1:0] q_data[$];

    stream_mux_rr #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Which channel the rules say is granted this cycle, or -1.
    function automatic int model_grant();
        int i;
        if (rst || !(!m_valid || out_ready)) return -1;
        if (mode == 1'b0) begin
            if (int'(sel) < N_CH && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N_CH; k++) begin
            i = (m_ptr + k) % N_CH;
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        int g;
        logic [N_CH-1:0] exp_ready;
        logic [WIDTH-1:0] d;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("m_in_ready", 32'(in_ready), 32'(exp_ready));
        check("m_out_valid", 32'(out_valid), 32'(m_valid));
        check("m_out_data", 32'(out_data), 32'(m_data));
        check("m_out_ch", 32'(out_ch), 32'(m_ch));
        if (!rst && m_valid && out_ready) begin
            if (q_ch.size() == 0) begin
                check("sb_nonempty", 32'(0), 32'(1));
            end else begin
                check("sb_ch", 32'(out_ch), 32'(q_ch.pop_front()));
                check("sb_data", 32'(out_data), 32'(q_data.pop_front()));
            end
        end
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = 0;
            q_ch.delete();
            q_data.delete();
        end else if (!m_valid || out_ready) begin
            if (g >= 0) begin
                d       = in_data[g*WIDTH +: WIDTH];
                m_valid = 1'b1;
                m_data  = d;
                m_ch    = g;
                q_ch.push_back(g);
                q_data.push_back(d);
                if (mode == 1'b1) m_ptr = (g + 1) % N_CH;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '1; in_data = '0; out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);

        // Fixed select of channel 2.
        tick();
        rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 32'h44A52211;
        @(negedge clk);
        check("fix_in_ready", 32'(in_ready), 32'b0100);
        tick();
        in_valid = '0;
        @(negedge clk);
        check("fix_out_data", 32'(out_data), 32'hA5);
        check("fix_out_ch", 32'(out_ch), 32'd2);
        check("fix_out_valid", 32'(out_valid), 32'd1);

        // Round-robin over all-valid inputs from ptr=0.
        tick();
        mode = 1'b1; in_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rr_seq_ready", 32'(in_ready), 32'(1 << (c % 4)));
            if (c > 0) check("rr_seq_out_ch", 32'(out_ch), 32'((c - 1) % 4));
            tick();
        end
        @(negedge clk);
        check("rr_ch2_ready", 32'(in_ready), 32'b0100);
        check("rr_ch2_out_ch", 32'(out_ch), 32'd1);

        // ptr=3 with only ch1 requesting wraps to ch1, ptr becomes 2.
        tick();
        in_valid = 4'b0010;
        @(negedge clk);
        check("wrap_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'hF;
        @(negedge clk);
        check("wrap_ptr2_ready", 32'(in_ready), 32'b0100);

        // Backpressure: output stays put and nothing is accepted.
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_ch", 32'(out_ch), 32'd2);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'b1000);
        check("bp_release_out_ch", 32'(out_ch), 32'd2);

        // Reset while the output register is full.
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        check("midrst_out_ch", 32'(out_ch), 32'd3);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        check("postrst_out_ch", 32'(out_ch), 32'd0);
        check("postrst_ready", 32'(in_ready), 32'b0001);

        // Fixed select of an idle channel: output drains and goes invalid.
        tick();
        mode = 1'b0; sel = 2'd3; in_valid = 4'b0111;
        @(negedge clk);
        check("idle_sel_ready", 32'(in_ready), 32'h0);
        check("idle_sel_valid", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        check("idle_sel_drained", 32'(out_valid), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst       = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = SW'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 1) == 0) ? N_CH'($urandom) : N_CH'($urandom & $urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-003 SHALL have derived constant SW = clog2(N_CH), the select and channel-index width (minimum 1).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port in_data, input, N_CH*WIDTH bits, channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, N_CH bits, per-channel valid.
REQ-009 SHALL have port in_ready, output, N_CH bits, per-channel accept strobe.
REQ-010 SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-011 SHALL have port sel, input, SW bits, channel index used in fixed mode.
REQ-012 SHALL have port out_data, output, WIDTH bits, registered selected data.
REQ-013 SHALL have port out_ch, output, SW bits, source channel of out_data.
REQ-014 SHALL have port out_valid, output, 1 bit, output register holds data.
REQ-015 SHALL have port out_ready, input, 1 bit, downstream accept.

Function
REQ-016 SHALL define load = !out_valid || out_ready, evaluated each cycle.
REQ-017 In fixed mode, SHALL grant channel sel when load and in_valid[sel] are both 1; sel >= N_CH SHALL grant nothing.
REQ-018 In round-robin mode, SHALL grant the first i with in_valid[i]=1, scanning from ptr upward mod N_CH, when load=1.
REQ-019 in_ready SHALL be combinational, one-hot on the granted channel, and all-zero when there is no grant.
REQ-020 A transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1; out_data and out_ch SHALL be loaded next edge and out_valid set (latency 1).
REQ-021 With load=1 and no grant, out_valid SHALL clear next edge; out_data and out_ch SHALL hold.
REQ-022 With out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold, and in_ready SHALL be all zero.
REQ-023 Full throughput (one transfer per cycle) SHALL be sustained while out_ready=1.
REQ-024 ptr SHALL update to (granted index + 1) mod N_CH only on a round-robin transfer; the wrap from N_CH-1 goes to 0.
REQ-025 ptr SHALL hold on a fixed-mode transfer and when there is no grant.
REQ-026 A mode change SHALL take effect in the same cycle's arbitration; an item already in the output register is unaffected.
REQ-027 The block SHALL NOT drop or duplicate data: each accepted item appears on the output exactly once.

Reset
REQ-028 While rst=1, the block SHALL drive out_valid=0 and in_ready all zero, and force out_data=0, out_ch=0, ptr=0 at the edge.
REQ-029 Reset mid-transfer SHALL discard the output register contents; no handshake SHALL complete in a reset cycle.

Structure
REQ-030 Package stream_mux_pkg SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the clog2 helper function.
REQ-031 Round-robin priority selection SHALL be a sub-module rr_arbiter, with inputs req[N_CH] and ptr and outputs grant one-hot plus grant index.
REQ-032 The top level SHALL hold the output register, ptr and fixed/RR grant multiplexing.

Verification (N_CH=4, WIDTH=8)
REQ-033 Fixed mode, sel=2, in_valid=4'b1111, data ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_ch=2, out_valid=1.
REQ-034 RR mode, all valid for 6 cycles, ptr=0 -> grants ch0,1,2,3,0,1; out_ch follows one cycle later.
REQ-035 RR mode, ptr=3, in_valid=4'b0010 -> grant ch1 (wrap); ptr becomes 2.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; out_ready=1 -> pending item accepted and the next item loaded the same edge.
REQ-037 rst asserted while out_valid=1 and in_valid=4'b1111 -> next cycle out_valid=0, out_ch=0, ptr=0; the first RR grant after reset is ch0.
REQ-038 Fixed mode, sel=3, in_valid=4'b0111 -> in_ready=0 and out_valid drops after the current item drains.
